// File: rtl/player_input_unit_pkg.sv
// player_input_unit_pkg: shared widths, sequence length, FSM encoding and key priority helper.
// Optional feature macro used by this slice: PLAYER_DEBOUNCE_EN (enables the debounce counter).
package player_input_unit_pkg;

    localparam int TILE_W   = 2;
    localparam int SEQ_LEN  = 9;
    localparam int SEQ_W    = 18;
    localparam int CNT_W    = 6;
    localparam int NUM_KEYS = 4;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURED,
        WAIT_RELEASE
    } state_t;

    // Lowest-indexed asserted event wins when several keys fire together.
    function automatic logic [TILE_W-1:0] lowest_key(input logic [NUM_KEYS-1:0] ev);
        lowest_key = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--)
            if (ev[k]) lowest_key = TILE_W'(k);
    endfunction

endpackage

// File: rtl/player_input_unit_if.sv
// player_input_unit_if: link between graphics control and the player input unit.
// master (graphics control): drives playerEN, checkEN, seq, sequence_counter;
//                            reads player_input, player_start, check, pressed_tile.
// slave  (player input unit): the reverse directions.
interface player_input_unit_if;
    import player_input_unit_pkg::*;

    logic              playerEN;
    logic              checkEN;
    logic [SEQ_W-1:0]  seq;
    logic [CNT_W-1:0]  sequence_counter;
    logic              player_input;
    logic              player_start;
    logic              check;
    logic [TILE_W-1:0] pressed_tile;

    modport master (
        output playerEN, checkEN, seq, sequence_counter,
        input  player_input, player_start, check, pressed_tile
    );

    modport slave (
        input  playerEN, checkEN, seq, sequence_counter,
        output player_input, player_start, check, pressed_tile
    );

endinterface

// File: rtl/player_input_unit_key_debounce.sv
// key_debounce: 2-flop synchroniser, optional debounce counter, registered press (1->0) pulse.
// Ports: clock, resetn (sync, active-low), raw (active-low button),
//        level (debounced level, 1 = released), fall (one-cycle press event).
// PLAYER_DEBOUNCE_EN defined: level follows the synchroniser only after DEBOUNCE_CYCLES
// consecutive differing samples; undefined: level is the synchroniser output.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic resetn,
    input  logic raw,
    output logic level,
    output logic fall
);

    logic       s1, s2, prev, rel;
    logic [1:0] settle;

    // rel stays low until the synchroniser has refilled after reset and shows the
    // button released, so a button held through reset needs a release and re-press.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            prev   <= 1'b1;
            rel    <= 1'b0;
            settle <= 2'b00;
            fall   <= 1'b0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            prev   <= level;
            settle <= {settle[0], 1'b1};
            rel    <= rel | (settle[1] & s2);
            fall   <= rel & prev & ~level;
        end
    end

`ifdef PLAYER_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt   <= '0;
            level <= 1'b1;
        end else if (s2 == level) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            level <= s2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign level = s2;
`endif

endmodule

// File: rtl/player_input_unit.sv
// player_input_unit: captures a debounced tile press and compares it with the expected tile.
// Ports: clock, resetn (sync, active-low), key[3:0] / start_key (raw, active-low),
//        bus (slave side of player_input_unit_if).
// Optional feature: define PLAYER_DEBOUNCE_EN to enable the debounce counters.
module player_input_unit #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SEQ_LEN         = player_input_unit_pkg::SEQ_LEN
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [3:0]                key,
    input  logic                      start_key,
    player_input_unit_if.slave        bus
);
    import player_input_unit_pkg::*;

    state_t            state;
    logic [NUM_KEYS:0] raw, level, fall;
    logic [TILE_W-1:0] pressed_tile;
    logic              player_input, player_start, check, tile_hit;

    // Bit NUM_KEYS carries the start button alongside the four tile keys.
    assign raw = {start_key, key};

    genvar i;
    for (i = 0; i <= NUM_KEYS; i++) begin : g_deb
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clock  (clock),
            .resetn (resetn),
            .raw    (raw[i]),
            .level  (level[i]),
            .fall   (fall[i])
        );
    end

    // Tile n is {seq[2n], seq[2n+1]}; an out-of-range index matches nothing.
    always_comb begin
        tile_hit = 1'b0;
        for (int n = 0; n < SEQ_LEN; n++)
            if (bus.sequence_counter == CNT_W'(n) && {bus.seq[2*n], bus.seq[2*n+1]} == pressed_tile)
                tile_hit = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state        <= IDLE;
            player_input <= 1'b0;
            player_start <= 1'b0;
            check        <= 1'b0;
            pressed_tile <= '0;
        end else begin
            player_start <= fall[NUM_KEYS];
            case (state)
                IDLE:
                    if (bus.playerEN) state <= ARMED;
                ARMED:
                    if (!bus.playerEN) begin
                        state <= IDLE;
                    end else if (|fall[NUM_KEYS-1:0]) begin
                        state        <= CAPTURED;
                        player_input <= 1'b1;
                        pressed_tile <= lowest_key(fall[NUM_KEYS-1:0]);
                    end
                CAPTURED:
                    if (bus.checkEN) begin
                        state        <= WAIT_RELEASE;
                        player_input <= 1'b0;
                        check        <= tile_hit;
                    end
                WAIT_RELEASE:
                    if (&level[NUM_KEYS-1:0]) state <= IDLE;
                default:
                    state <= IDLE;
            endcase
        end
    end

    assign bus.player_input = player_input;
    assign bus.player_start = player_start;
    assign bus.check        = check;
    assign bus.pressed_tile = pressed_tile;

endmodule

// File: tb/tb_player_input_unit.sv
// tb_player_input_unit: directed self-checking bench for player_input_unit.
module tb_player_input_unit;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] key = 4'hF;
    logic       start_key = 1'b1;
    int         checks = 0;
    int         errors = 0;

    player_input_unit_if bus();

    player_input_unit #(.DEBOUNCE_CYCLES(4)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .key       (key),
        .start_key (start_key),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_capture(output bit ok);
        int i = 0;
        while (!bus.player_input && i < 60) begin
            @(negedge clock);
            i++;
        end
        ok = bus.player_input;
    endtask

    task automatic pulse_check;
        bus.checkEN = 1'b1;
        @(negedge clock);
        bus.checkEN = 1'b0;
    endtask

    task automatic count_start(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clock);
            if (bus.player_start) c++;
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        bus.playerEN = 1'b0;
        bus.checkEN = 1'b0;
        bus.seq = 18'h00001;
        bus.sequence_counter = 6'd0;
        tick(3);
        checks++; if (bus.player_input !== 1'b0) begin errors++; $display("FAIL reset_player_input: got %b expected 0", bus.player_input); end
        checks++; if (bus.player_start !== 1'b0) begin errors++; $display("FAIL reset_player_start: got %b expected 0", bus.player_start); end
        checks++; if (bus.check !== 1'b0) begin errors++; $display("FAIL reset_check: got %b expected 0", bus.check); end
        checks++; if (bus.pressed_tile !== 2'd0) begin errors++; $display("FAIL reset_pressed_tile: got %0d expected 0", bus.pressed_tile); end
        resetn = 1'b1;
        tick(5);
    endtask

    task automatic test_match;
        bit ok;
        bus.playerEN = 1'b1;
        tick(3);
        key = 4'b1011;
        wait_capture(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL match_capture: got %b expected 1", ok); end
        checks++; if (bus.pressed_tile !== 2'd2) begin errors++; $display("FAIL match_tile: got %0d expected 2", bus.pressed_tile); end
        pulse_check;
        checks++; if (bus.check !== 1'b1) begin errors++; $display("FAIL match_check: got %b expected 1", bus.check); end
        checks++; if (bus.player_input !== 1'b0) begin errors++; $display("FAIL match_input_clear: got %b expected 0", bus.player_input); end
        key = 4'hF;
        tick(12);
    endtask

    task automatic test_mismatch;
        bit ok;
        key = 4'b1101;
        wait_capture(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mismatch_capture: got %b expected 1", ok); end
        checks++; if (bus.pressed_tile !== 2'd1) begin errors++; $display("FAIL mismatch_tile: got %0d expected 1", bus.pressed_tile); end
        pulse_check;
        checks++; if (bus.check !== 1'b0) begin errors++; $display("FAIL mismatch_check: got %b expected 0", bus.check); end
        key = 4'hF;
        tick(12);
    endtask

    task automatic test_simultaneous;
        bit ok;
        key = 4'b0110;
        wait_capture(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL simul_capture: got %b expected 1", ok); end
        checks++; if (bus.pressed_tile !== 2'd0) begin errors++; $display("FAIL simul_tile: got %0d expected 0", bus.pressed_tile); end
        key = 4'b0100;
        tick(10);
        checks++; if (bus.pressed_tile !== 2'd0) begin errors++; $display("FAIL simul_hold_tile: got %0d expected 0", bus.pressed_tile); end
        pulse_check;
        key = 4'b0000;
        tick(10);
        checks++; if (bus.player_input !== 1'b0) begin errors++; $display("FAIL simul_wait_release: got %b expected 0", bus.player_input); end
        key = 4'hF;
        tick(12);
        checks++; if (bus.player_input !== 1'b0) begin errors++; $display("FAIL simul_after_release: got %b expected 0", bus.player_input); end
        key = 4'b1011;
        wait_capture(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL simul_repress: got %b expected 1", ok); end
        checks++; if (bus.pressed_tile !== 2'd2) begin errors++; $display("FAIL simul_repress_tile: got %0d expected 2", bus.pressed_tile); end
        pulse_check;
        checks++; if (bus.check !== 1'b1) begin errors++; $display("FAIL simul_repress_check: got %b expected 1", bus.check); end
        key = 4'hF;
        tick(12);
    endtask

    task automatic test_preheld;
        bit ok;
        bus.playerEN = 1'b0;
        tick(3);
        key = 4'b1101;
        tick(10);
        bus.playerEN = 1'b1;
        tick(15);
        checks++; if (bus.player_input !== 1'b0) begin errors++; $display("FAIL preheld_ignored: got %b expected 0", bus.player_input); end
        key = 4'hF;
        tick(12);
        key = 4'b1101;
        wait_capture(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL preheld_repress: got %b expected 1", ok); end
        checks++; if (bus.pressed_tile !== 2'd1) begin errors++; $display("FAIL preheld_tile: got %0d expected 1", bus.pressed_tile); end
        pulse_check;
        key = 4'hF;
        tick(12);
    endtask

    task automatic test_reset_mid;
        bit ok;
        bus.seq = 18'h0000D;
        bus.sequence_counter = 6'd1;
        key = 4'b0111;
        wait_capture(ok);
        pulse_check;
        checks++; if (bus.check !== 1'b1) begin errors++; $display("FAIL tile1_check: got %b expected 1", bus.check); end
        key = 4'hF;
        tick(12);
        key = 4'b0111;
        wait_capture(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_capture: got %b expected 1", ok); end
        resetn = 1'b0;
        @(negedge clock);
        checks++; if (bus.player_input !== 1'b0) begin errors++; $display("FAIL rstmid_input: got %b expected 0", bus.player_input); end
        checks++; if (bus.check !== 1'b0) begin errors++; $display("FAIL rstmid_check: got %b expected 0", bus.check); end
        resetn = 1'b1;
        tick(20);
        checks++; if (bus.player_input !== 1'b0) begin errors++; $display("FAIL rstmid_held_key: got %b expected 0", bus.player_input); end
        key = 4'hF;
        tick(12);
        key = 4'b0111;
        wait_capture(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_repress: got %b expected 1", ok); end
        pulse_check;
        checks++; if (bus.check !== 1'b1) begin errors++; $display("FAIL rstmid_repress_check: got %b expected 1", bus.check); end
        key = 4'hF;
        tick(12);
        key = 4'b0111;
        wait_capture(ok);
        bus.sequence_counter = 6'd9;
        pulse_check;
        checks++; if (bus.check !== 1'b0) begin errors++; $display("FAIL range_check: got %b expected 0", bus.check); end
        key = 4'hF;
        bus.sequence_counter = 6'd0;
        tick(12);
    endtask

    task automatic test_start;
        bit ok;
        int c;
        start_key = 1'b0;
        count_start(20, c);
        checks++; if (c !== 1) begin errors++; $display("FAIL start_pulse: got %0d pulses expected 1", c); end
        start_key = 1'b1;
        tick(12);
        key = 4'b1110;
        start_key = 1'b0;
        count_start(20, c);
        checks++; if (c !== 1) begin errors++; $display("FAIL start_with_key_pulse: got %0d pulses expected 1", c); end
        wait_capture(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL start_with_key_capture: got %b expected 1", ok); end
        checks++; if (bus.pressed_tile !== 2'd0) begin errors++; $display("FAIL start_with_key_tile: got %0d expected 0", bus.pressed_tile); end
        pulse_check;
        key = 4'hF;
        start_key = 1'b1;
        tick(12);
    endtask

`ifdef PLAYER_DEBOUNCE_EN
    task automatic test_debounce;
        bit ok;
        int c1, c2;
        key = 4'b1101;
        tick(3);
        key = 4'hF;
        tick(20);
        checks++; if (bus.player_input !== 1'b0) begin errors++; $display("FAIL glitch_key: got %b expected 0", bus.player_input); end
        start_key = 1'b0;
        count_start(3, c1);
        start_key = 1'b1;
        count_start(20, c2);
        checks++; if (c1 + c2 !== 0) begin errors++; $display("FAIL glitch_start: got %0d pulses expected 0", c1 + c2); end
        start_key = 1'b0;
        count_start(6, c1);
        start_key = 1'b1;
        count_start(20, c2);
        checks++; if (c1 + c2 !== 1) begin errors++; $display("FAIL stable_start: got %0d pulses expected 1", c1 + c2); end
        key = 4'b1101;
        tick(6);
        key = 4'hF;
        wait_capture(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stable_key: got %b expected 1", ok); end
        checks++; if (bus.pressed_tile !== 2'd1) begin errors++; $display("FAIL stable_key_tile: got %0d expected 1", bus.pressed_tile); end
        pulse_check;
        tick(15);
    endtask
`endif

    initial begin
        test_reset;
        test_match;
        test_mismatch;
        test_simultaneous;
        test_preheld;
        test_reset_mid;
        test_start;
`ifdef PLAYER_DEBOUNCE_EN
        test_debounce;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
